udp_tx_arb: RTL and testbench

- Packet-granular round-robin arbiter that shares the single UDP stream TX port (tx_length/tx_data/tx_valid/tx_ready/tx_last) between NUM_REQ requesters.
- Requester 0 is the video packetiser; others are telemetry/status generators.
- Sits between the packet sources and udp_stream in the csi_byte_clk domain.
- Holds a grant from first beat to tx_last, and truncates runaway packets at MAX_BEATS.

---
 rtl/udp_tx_arb_pkg.sv | 18 +
 rtl/udp_tx_arb_rr_pick.sv | 26 ++
 rtl/udp_tx_arb.sv | 134 +++++++++++++
 tb/tb_udp_tx_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_arb_pkg.sv
// rtl/udp_tx_arb_pkg.sv - shared types and limits for the UDP TX round-robin arbiter
package udp_tx_arb_pkg;

  typedef logic [7:0]  bus8_t;
  typedef logic [15:0] bus16_t;

  localparam int UDP_MAX_PAYLOAD = 1472;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_t;

  typedef struct packed {
    bus16_t length;
    bus8_t  data;
    logic   valid;
    logic   last;
  } arb_req_t;

endpackage

// File: rtl/udp_tx_arb_rr_pick.sv
// rtl/udp_tx_arb_rr_pick.sv - combinational round-robin picker, searches from last_grant+1
module udp_tx_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last_grant,
  output logic [2:0]         grant,
  output logic               any
);

  int idx;

  // Walk the ring backwards so the nearest requester after last_grant wins.
  always_comb begin
    grant = last_grant;
    any   = |req;
    idx   = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == idx && req[k]) grant = 3'(k);
      end
    end
  end

endmodule

// File: rtl/udp_tx_arb.sv
// rtl/udp_tx_arb.sv - packet-granular round-robin arbiter for the UDP stream TX port
// Optional per-requester statistics behind `UDP_ARB_STATS_EN.
module udp_tx_arb
  import udp_tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BEATS = UDP_MAX_PAYLOAD
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic [NUM_REQ*16-1:0] req_length,
  input  logic [NUM_REQ*8-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           tx_length,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [2:0]            grant_id,
  output logic                  trunc_pulse
`ifdef UDP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_pkts,
  output logic [15:0]           stat_trunc
`endif
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  arb_state_t    state;
  logic [CW-1:0] beat_cnt;
  arb_req_t      sel;
  logic [2:0]    pick_idx;
  logic [2:0]    sel_idx;
  logic          pick_any;
  logic          xfer;
  logic          at_limit;
  logic          fire;

  // Assert asynchronously, release two clocks after areset_n rises.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  udp_tx_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (grant_id),
    .grant      (pick_idx),
    .any        (pick_any)
  );

  // In IDLE the mux looks at the candidate so its length can be latched.
  always_comb begin
    sel_idx = (state == IDLE) ? pick_idx : grant_id;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 3'(i)) begin
        sel = '{length: req_length[i*16 +: 16], data: req_data[i*8 +: 8],
                valid: req_valid[i], last: req_last[i]};
      end
    end
  end

  assign xfer        = (state == XFER);
  assign at_limit    = (beat_cnt == CW'(MAX_BEATS - 1));
  assign tx_valid    = xfer & sel.valid;
  assign tx_data     = xfer ? sel.data : 8'h00;
  assign tx_last     = tx_valid & (sel.last | at_limit);
  assign fire        = tx_valid & tx_ready;
  assign trunc_pulse = fire & at_limit & ~sel.last;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) req_ready[i] = (xfer & tx_ready) | (state == DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= 3'(NUM_REQ - 1);
      tx_length <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_idx;
            tx_length <= sel.length;
            state     <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            if (sel.last || at_limit) begin
              beat_cnt <= '0;
              state    <= sel.last ? IDLE : DRAIN;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (sel.valid && sel.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkts  <= '0;
      stat_trunc <= '0;
    end else begin
      if (fire && tx_last) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == 3'(i)) stat_pkts[i*16 +: 16] <= stat_pkts[i*16 +: 16] + 16'd1;
        end
      end
      if (trunc_pulse) stat_trunc <= stat_trunc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb/tb_udp_tx_arb.sv - scoreboard bench for udp_tx_arb with a packet-level reference model
module tb_udp_tx_arb;

  localparam int NR   = 2;
  localparam int MAXB = 8;

  typedef struct {logic [7:0] d; logic l; logic [15:0] len;} stim_t;
  typedef struct {logic [7:0] d; logic l; logic t; logic [15:0] len;} exp_t;

  logic             clk = 1'b0;
  logic             areset_n;
  logic [NR*16-1:0] req_length;
  logic [NR*8-1:0]  req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [15:0]      tx_length;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_last;
  logic [2:0]       grant_id;
  logic             trunc_pulse;
`ifdef UDP_ARB_STATS_EN
  logic [NR*16-1:0] stat_pkts;
  logic [15:0]      stat_trunc;
`endif

  always #5 clk = ~clk;

  udp_tx_arb #(.NUM_REQ(NR), .MAX_BEATS(MAXB)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .req_length  (req_length),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_length   (tx_length),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .grant_id    (grant_id),
    .trunc_pulse (trunc_pulse)
`ifdef UDP_ARB_STATS_EN
    ,
    .stat_pkts   (stat_pkts),
    .stat_trunc  (stat_trunc)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  stim_t stim_q [NR][$];
  exp_t  exp_q  [NR][$];
  int    pend [NR];
  bit    started [NR];
  bit    prev_v [NR];
  int    present_cyc [NR];
  int    exp_pkts [NR];
  int    exp_trunc;
  bit    rdy_rand, gap_en, in_rst;
  logic [NR-1:0] hs;

  bit in_pkt, drain, after_last;
  int cur, last_g, pkt_beats, start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected output per packet: at most MAXB beats, last forced on beat MAXB.
  task automatic add_pkt(int r, int n, logic [15:0] len);
    stim_t s;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      s.d = 8'($urandom);
      s.l = (k == n - 1);
      s.len = len;
      stim_q[r].push_back(s);
      if (k < MAXB) begin
        e.d = s.d;
        e.l = (k == n - 1) || (k == MAXB - 1);
        e.t = (k == MAXB - 1) && (n > MAXB);
        e.len = len;
        exp_q[r].push_back(e);
      end
    end
    pend[r]++;
    exp_pkts[r]++;
    if (n > MAXB) exp_trunc++;
  endtask

  function automatic int rr_model();
    for (int i = 1; i <= NR; i++) begin
      int j;
      j = (last_g + i) % NR;
      if (pend[j] > 0) return j;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = in_pkt || drain || after_last;
    for (int r = 0; r < NR; r++) b = b || (stim_q[r].size() > 0) || (exp_q[r].size() > 0);
    return b;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NR; r++) begin
      stim_q[r].delete();
      exp_q[r].delete();
      pend[r] = 0;
      started[r] = 0;
      prev_v[r] = 0;
      exp_pkts[r] = 0;
    end
    exp_trunc = 0;
    in_pkt = 0;
    drain = 0;
    after_last = 0;
    cur = 0;
    last_g = NR - 1;
    pkt_beats = 0;
  endtask

  task automatic check_stats();
`ifdef UDP_ARB_STATS_EN
    for (int r = 0; r < NR; r++) chk("stat_pkts", 32'(stat_pkts[r*16 +: 16]), 32'(exp_pkts[r]));
    chk("stat_trunc", 32'(stat_trunc), 32'(exp_trunc));
`endif
  endtask

  // Driver: applies inputs mid-cycle and records which handshakes the next edge will take.
  initial begin
    hs = '0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    req_length = '0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        hs = '0;
        req_valid = '0;
        req_last = '0;
        tx_ready = 1'b1;
      end else begin
        for (int r = 0; r < NR; r++) begin
          if (hs[r] && stim_q[r].size() > 0) begin
            if (stim_q[r][0].l) begin
              pend[r]--;
              started[r] = 0;
            end else begin
              started[r] = 1;
            end
            stim_q[r].delete(0);
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (stim_q[r].size() > 0 && !(gap_en && started[r] && $urandom_range(0, 3) == 0)) begin
            req_valid[r] = 1'b1;
            req_data[r*8 +: 8] = stim_q[r][0].d;
            req_last[r] = stim_q[r][0].l;
            req_length[r*16 +: 16] = stim_q[r][0].len;
            if (!prev_v[r] && !started[r]) present_cyc[r] = cyc;
          end else begin
            req_valid[r] = 1'b0;
            req_last[r] = 1'b0;
          end
          prev_v[r] = req_valid[r];
        end
        tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      hs = req_valid & req_ready;
    end
  end

  task automatic mon_step();
    logic [NR-1:0] oh;
    exp_t e;
    int g;
    oh = '0;
    oh[cur] = 1'b1;
    if (after_last) begin
      chk("gap_tx_valid", 32'(tx_valid), 0);
      chk("gap_req_ready", 32'(req_ready), 0);
      after_last = 0;
    end else if (drain) begin
      chk("drain_tx_valid", 32'(tx_valid), 0);
      chk("drain_req_ready", 32'(req_ready), 32'(oh));
      if (req_valid[cur] && req_last[cur]) begin
        drain = 0;
        after_last = 1;
      end
    end else if (tx_valid) begin
      if (!in_pkt) begin
        g = rr_model();
        chk("grant_id", 32'(grant_id), 32'(g));
        if (g < 0) g = 0;
        cur = g;
        last_g = g;
        in_pkt = 1;
        pkt_beats = 0;
        start_cyc = cyc;
        oh = '0;
        oh[cur] = 1'b1;
      end
      chk("req_ready_mirror", 32'(req_ready), tx_ready ? 32'(oh) : 0);
      if (tx_ready) begin
        if (exp_q[cur].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h from req %0d, expected none", tx_data, cur);
        end else begin
          e = exp_q[cur].pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.d));
          chk("tx_last", 32'(tx_last), 32'(e.l));
          chk("trunc_pulse", 32'(trunc_pulse), 32'(e.t));
          chk("tx_length", 32'(tx_length), 32'(e.len));
          pkt_beats++;
          if (e.l) begin
            in_pkt = 0;
            if (e.t) drain = 1;
            else after_last = 1;
          end
        end
      end else begin
        chk("trunc_stalled", 32'(trunc_pulse), 0);
      end
    end else begin
      chk("trunc_idle", 32'(trunc_pulse), 0);
      chk("req_ready_quiet", 32'(req_ready), (in_pkt && tx_ready) ? 32'(oh) : 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst && areset_n) mon_step();
    end
  end

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (busy() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (busy()) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: still busy after %0d cycles, expected idle", tag, n);
      clear_model();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int n;
    areset_n = 1'b0;
    in_rst = 1'b1;
    rdy_rand = 1'b0;
    gap_en = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_last", 32'(tx_last), 0);
    chk("rst_tx_length", 32'(tx_length), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_trunc", 32'(trunc_pulse), 0);
    chk("rst_grant_id", 32'(grant_id), NR - 1);
    areset_n = 1'b1;
    repeat (4) @(posedge clk);
    in_rst = 1'b0;
    check_stats();

    add_pkt(0, 4, 16'd4);
    wait_idle("single");
    chk("arb_latency", 32'(start_cyc - present_cyc[0]), 1);

    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 5, 16'd5);
      add_pkt(1, 5, 16'd5);
    end
    wait_idle("alternate");
    check_stats();

    add_pkt(1, 12, 16'd12);
    wait_idle("truncate");
    check_stats();

    rdy_rand = 1'b1;
    add_pkt(0, MAXB, 16'(MAXB));
    add_pkt(1, 10, 16'd10);
    wait_idle("random_ready");

    gap_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(1, 12);
      add_pkt($urandom_range(0, NR - 1), n, 16'(n));
    end
    wait_idle("random_mix");
    check_stats();

    rdy_rand = 1'b0;
    gap_en = 1'b0;
    add_pkt(1, 10, 16'd10);
    n = 0;
    while (!(in_pkt && cur == 1 && pkt_beats >= 4) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("reset_setup_reached", 32'(n < 200), 1);
    @(negedge clk);
    #3;
    in_rst = 1'b1;
    areset_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_tx_last", 32'(tx_last), 0);
    chk("midrst_grant_id", 32'(grant_id), NR - 1);
    clear_model();
    repeat (3) @(posedge clk);
    areset_n = 1'b1;
    repeat (4) @(posedge clk);
    in_rst = 1'b0;
    check_stats();
    add_pkt(1, 3, 16'd3);
    add_pkt(0, 3, 16'd3);
    wait_idle("after_reset");
    check_stats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
